dcache_responder: RTL and testbench

- Responder end of the backend load/store data-cache interface: services load/store requests issued by the backend master.
- Direct-mapped, write-through, no-write-allocate, blocking data cache.
- Refills lines over a burst read port and forwards every store over a single-beat write port.
- Supports an index-invalidate operation driven by the cache-instruction path.

---
 rtl/dcache_responder.sv | 193 +++++++++++++++++++
 tb/tb_dcache_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate blocking data cache that answers
// backend load/store requests, refilling over a burst read port and forwarding stores.
module dcache_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   req_uncached,
  input  logic [3:0]             req_wstrb,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  input  logic                   inv_valid,
  input  logic [INDEX_WIDTH-1:0] inv_index,
  output logic                   mem_rd_req,
  output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
  output logic [1:0]             mem_rd_len,
  input  logic                   mem_rd_ready,
  input  logic                   mem_ret_valid,
  input  logic                   mem_ret_last,
  input  logic [31:0]            mem_ret_data,
  output logic                   mem_wr_req,
  output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
  output logic [3:0]             mem_wr_wstrb,
  output logic [31:0]            mem_wr_data,
  input  logic                   mem_wr_ready
);

  localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINES      = 1 << INDEX_WIDTH;
  localparam int WORD_BITS  = OFFSET_WIDTH - 2;
  localparam int WORDS      = 1 << WORD_BITS;
  localparam logic [1:0] RD_LEN_LINE = 2'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RD_REQ, S_REFILL, S_RESP, S_WRITE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_op;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_uncached;
  logic [3:0]              r_wstrb;
  logic [31:0]             r_wdata;
  logic [WORD_BITS-1:0]    r_cnt;
  logic [31:0]             r_rdata;

  logic [LINES-1:0]        r_valid;
  logic [TAG_WIDTH-1:0]    r_tag  [LINES];
  logic [31:0]             r_data [LINES][WORDS];

  logic [TAG_WIDTH-1:0]    w_tag;
  logic [INDEX_WIDTH-1:0]  w_index;
  logic [WORD_BITS-1:0]    w_word;
  logic                    w_hit, w_ready, w_accept, w_inv;
  logic                    w_ret_beat, w_fill_beat, w_fill_done, w_capture, w_store_merge;

  assign w_tag   = r_addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH];
  assign w_index = r_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign w_word  = r_addr[OFFSET_WIDTH-1:2];
  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag) && !r_uncached;

  // Gated by rst so every output, including req_ready, reads 0 while in reset.
  assign w_ready   = (r_state == S_IDLE) && !inv_valid && rst;
  assign req_ready = w_ready;
  assign w_accept  = req_valid && w_ready;
  assign w_inv     = (r_state == S_IDLE) && inv_valid;

  assign w_ret_beat    = (r_state == S_REFILL) && mem_ret_valid;
  assign w_fill_beat   = w_ret_beat && !r_uncached;
  assign w_fill_done   = w_fill_beat && mem_ret_last;
  assign w_capture     = w_ret_beat && (r_uncached ? (r_cnt == '0) : (r_cnt == w_word));
  assign w_store_merge = (r_state == S_LOOKUP) && r_op && (r_wstrb != '0) && w_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_op       <= 1'b0;
      r_addr     <= '0;
      r_uncached <= 1'b0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op       <= req_op;
        r_addr     <= req_addr;
        r_uncached <= req_uncached;
        r_wstrb    <= req_wstrb;
        r_wdata    <= req_wdata;
      end
      if (r_state == S_RD_REQ) r_cnt <= '0;
      if (w_ret_beat) r_cnt <= r_cnt + 1'b1;
      if (w_capture) r_rdata <= mem_ret_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (w_inv) begin
      r_valid[inv_index] <= 1'b0;
    end else if (w_fill_done) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; valid bits alone decide
  // whether their contents are ever observed.
  always_ff @(posedge clk) begin
    if (w_fill_beat) begin
      r_data[w_index][r_cnt] <= mem_ret_data;
    end else if (w_store_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_data[w_index][w_word][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
    if (w_fill_done) r_tag[w_index] <= w_tag;
  end

  // NOTE: every output and the next state get a default first so no path
  // through the case leaves a latch behind.
  always_comb begin
    w_state_nxt  = r_state;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    mem_rd_req   = 1'b0;
    mem_rd_addr  = '0;
    mem_rd_len   = '0;
    mem_wr_req   = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_wstrb = '0;
    mem_wr_data  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!r_op) begin
          if (w_hit) begin
            resp_valid  = 1'b1;
            resp_rdata  = r_data[w_index][w_word];
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RD_REQ;
          end
        end else if (r_wstrb == '0) begin
          resp_valid  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_RD_REQ: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = r_uncached ? {r_addr[ADDR_WIDTH-1:2], 2'b00}
                                 : {r_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        mem_rd_len  = r_uncached ? 2'd0 : RD_LEN_LINE;
        if (mem_rd_ready) w_state_nxt = S_REFILL;
      end
      S_REFILL: begin
        if (mem_ret_valid && mem_ret_last) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid  = 1'b1;
        resp_rdata  = r_rdata;
        w_state_nxt = S_IDLE;
      end
      S_WRITE: begin
        mem_wr_req   = 1'b1;
        mem_wr_addr  = r_addr;
        mem_wr_wstrb = r_wstrb;
        mem_wr_data  = r_wdata;
        if (mem_wr_ready) begin
          resp_valid  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed testbench for dcache_responder: drives inputs at the falling edge,
// samples just after, and plays the memory side by hand.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_op, req_uncached;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        inv_valid;
  logic [5:0]  inv_index;
  logic        mem_rd_req, mem_rd_ready, mem_ret_valid, mem_ret_last;
  logic [31:0] mem_rd_addr, mem_ret_data;
  logic [1:0]  mem_rd_len;
  logic        mem_wr_req, mem_wr_ready;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_wr_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] beats [4];
  logic        t_ok, t_rd_seen, t_wr_seen, t_hold_ok;
  logic [31:0] t_rd, t_ra, t_wa, t_wd;
  logic [1:0]  t_rl;
  logic [3:0]  t_ws;
  int          t_lat;

  dcache_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_uncached(req_uncached), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .inv_valid(inv_valid), .inv_index(inv_index),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_ready(mem_rd_ready), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
    .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_wstrb(mem_wr_wstrb),
    .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_beats(input logic [31:0] base);
    for (int i = 0; i < 4; i++) beats[i] = base + 32'(i);
  endtask

  // Presents a request and returns at the sample point of the LOOKUP cycle.
  task automatic issue(input logic op, input logic [31:0] a, input logic unc,
                       input logic [3:0] s, input logic [31:0] d);
    int k;
    t_ok = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_uncached = unc;
    req_wstrb = s; req_wdata = d;
    #1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (!req_ready) t_ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  // Plays the memory side until the response pulse; records what was seen.
  task automatic run_txn();
    logic done;
    done = 1'b0; t_lat = 1; t_rd_seen = 1'b0; t_wr_seen = 1'b0; t_hold_ok = 1'b1;
    t_rd = 32'hxxxx_xxxx;
    for (int c = 0; c < 40 && !done; c++) begin
      if (resp_valid) begin
        t_rd = resp_rdata; done = 1'b1;
      end else if (mem_rd_req) begin
        t_rd_seen = 1'b1; t_ra = mem_rd_addr; t_rl = mem_rd_len;
        mem_rd_ready = 1'b1;
        @(negedge clk);
        mem_rd_ready = 1'b0;
        for (int b = 0; b <= int'(t_rl); b++) begin
          mem_ret_valid = 1'b1; mem_ret_data = beats[b]; mem_ret_last = (b == int'(t_rl));
          @(negedge clk);
        end
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
        #1;
        t_lat = 1;
      end else if (mem_wr_req) begin
        t_wr_seen = 1'b1; t_wa = mem_wr_addr; t_ws = mem_wr_wstrb; t_wd = mem_wr_data;
        @(negedge clk); #1;
        if (!mem_wr_req || resp_valid || mem_wr_addr !== t_wa || mem_wr_data !== t_wd) t_hold_ok = 1'b0;
        mem_wr_ready = 1'b1;
        #1;
        if (resp_valid) begin t_rd = resp_rdata; done = 1'b1; end
        @(negedge clk);
        mem_wr_ready = 1'b0;
        #1;
      end else begin
        @(negedge clk); #1; t_lat++;
      end
    end
    if (!done) t_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b1; req_op = 1'b0; req_addr = '0; req_uncached = 1'b0;
    req_wstrb = '0; req_wdata = '0; inv_valid = 1'b0; inv_index = '0;
    mem_rd_ready = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = '0;
    mem_wr_ready = 1'b0;
    #12;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if ({resp_valid, mem_rd_req, mem_wr_req} !== 3'b000) begin n_err++; $display("FAIL reset_valids: got %b want 000", {resp_valid, mem_rd_req, mem_wr_req}); end
    n_cmp++; if ({resp_rdata, mem_rd_addr, mem_wr_addr, mem_wr_data} !== 128'h0) begin n_err++; $display("FAIL reset_buses: got nonzero bus value"); end
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_cold_load();
    set_beats(32'hA0);
    issue(1'b0, 32'h1008, 1'b0, 4'h0, 32'h0); run_txn();
    n_cmp++; if (t_ok !== 1'b1) begin n_err++; $display("FAIL cold_timeout: got %b want 1", t_ok); end
    n_cmp++; if (t_rd_seen !== 1'b1) begin n_err++; $display("FAIL cold_rd_req: got %b want 1", t_rd_seen); end
    n_cmp++; if (t_ra !== 32'h1000) begin n_err++; $display("FAIL cold_rd_addr: got %h want 00001000", t_ra); end
    n_cmp++; if (t_rl !== 2'd3) begin n_err++; $display("FAIL cold_rd_len: got %0d want 3", t_rl); end
    n_cmp++; if (t_rd !== 32'hA2) begin n_err++; $display("FAIL cold_rdata: got %h want 000000a2", t_rd); end
    n_cmp++; if (t_lat !== 1) begin n_err++; $display("FAIL cold_latency: got %0d want 1", t_lat); end
    issue(1'b0, 32'h100C, 1'b0, 4'h0, 32'h0); run_txn();
    n_cmp++; if (t_rd_seen !== 1'b0) begin n_err++; $display("FAIL hit_no_rd_req: got %b want 0", t_rd_seen); end
    n_cmp++; if (t_rd !== 32'hA3) begin n_err++; $display("FAIL hit_rdata: got %h want 000000a3", t_rd); end
    n_cmp++; if (t_lat !== 1) begin n_err++; $display("FAIL hit_latency: got %0d want 1", t_lat); end
  endtask

  task automatic test_store_hit();
    issue(1'b1, 32'h1004, 1'b0, 4'b0011, 32'h1234_5678); run_txn();
    n_cmp++; if (t_wr_seen !== 1'b1 || t_ok !== 1'b1) begin n_err++; $display("FAIL st_hit_wr_req: got %b want 1", t_wr_seen); end
    n_cmp++; if ({t_wa, t_ws, t_wd} !== {32'h1004, 4'b0011, 32'h1234_5678}) begin n_err++; $display("FAIL st_hit_wr_fields: got %h/%b/%h want 00001004/0011/12345678", t_wa, t_ws, t_wd); end
    n_cmp++; if (t_hold_ok !== 1'b1) begin n_err++; $display("FAIL st_hit_hold: got %b want 1", t_hold_ok); end
    n_cmp++; if (t_rd !== 32'h0) begin n_err++; $display("FAIL st_hit_resp_rdata: got %h want 00000000", t_rd); end
    n_cmp++; if (t_rd_seen !== 1'b0) begin n_err++; $display("FAIL st_hit_no_refill: got %b want 0", t_rd_seen); end
    issue(1'b0, 32'h1004, 1'b0, 4'h0, 32'h0); run_txn();
    n_cmp++; if (t_rd_seen !== 1'b0) begin n_err++; $display("FAIL merged_hit: got %b want 0", t_rd_seen); end
    n_cmp++; if (t_rd !== 32'h0000_5678) begin n_err++; $display("FAIL merged_rdata: got %h want 00005678", t_rd); end
  endtask

  task automatic test_uncached();
    set_beats(32'h55);
    issue(1'b0, 32'h1008, 1'b1, 4'h0, 32'h0); run_txn();
    n_cmp++; if (t_rd_seen !== 1'b1) begin n_err++; $display("FAIL unc_rd_req: got %b want 1", t_rd_seen); end
    n_cmp++; if (t_ra !== 32'h1008) begin n_err++; $display("FAIL unc_rd_addr: got %h want 00001008", t_ra); end
    n_cmp++; if (t_rl !== 2'd0) begin n_err++; $display("FAIL unc_rd_len: got %0d want 0", t_rl); end
    n_cmp++; if (t_rd !== 32'h55) begin n_err++; $display("FAIL unc_rdata: got %h want 00000055", t_rd); end
    issue(1'b0, 32'h1008, 1'b0, 4'h0, 32'h0); run_txn();
    n_cmp++; if (t_rd_seen !== 1'b0) begin n_err++; $display("FAIL unc_array_hit: got %b want 0", t_rd_seen); end
    n_cmp++; if (t_rd !== 32'hA2) begin n_err++; $display("FAIL unc_array_data: got %h want 000000a2", t_rd); end
  endtask

  task automatic test_invalidate();
    @(negedge clk);
    inv_valid = 1'b1; inv_index = 6'd0;
    req_valid = 1'b1; req_op = 1'b0; req_addr = 32'h1000; req_uncached = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL inv_blocks_req: got %b want 0", req_ready); end
    @(negedge clk);
    inv_valid = 1'b0; req_valid = 1'b0;
    set_beats(32'hC0);
    issue(1'b0, 32'h1000, 1'b0, 4'h0, 32'h0); run_txn();
    n_cmp++; if (t_rd_seen !== 1'b1) begin n_err++; $display("FAIL inv_miss: got %b want 1", t_rd_seen); end
    n_cmp++; if (t_rd !== 32'hC0) begin n_err++; $display("FAIL inv_refill_data: got %h want 000000c0", t_rd); end
  endtask

  task automatic test_store_miss();
    issue(1'b1, 32'h2000, 1'b0, 4'hF, 32'hDEAD_BEEF); run_txn();
    n_cmp++; if (t_wr_seen !== 1'b1 || t_wa !== 32'h2000 || t_wd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL st_miss_write: got %b/%h/%h want 1/00002000/deadbeef", t_wr_seen, t_wa, t_wd); end
    n_cmp++; if (t_rd_seen !== 1'b0) begin n_err++; $display("FAIL st_miss_no_alloc: got %b want 0", t_rd_seen); end
    set_beats(32'hB0);
    issue(1'b0, 32'h2000, 1'b0, 4'h0, 32'h0); run_txn();
    n_cmp++; if (t_rd_seen !== 1'b1 || t_ra !== 32'h2000) begin n_err++; $display("FAIL ld_after_st_miss: got %b/%h want 1/00002000", t_rd_seen, t_ra); end
    n_cmp++; if (t_rd !== 32'hB0) begin n_err++; $display("FAIL ld_after_st_miss_data: got %h want 000000b0", t_rd); end
  endtask

  task automatic test_zero_strobe();
    issue(1'b1, 32'h2004, 1'b0, 4'h0, 32'h1111_1111); run_txn();
    n_cmp++; if (t_wr_seen !== 1'b0) begin n_err++; $display("FAIL zstrb_no_write: got %b want 0", t_wr_seen); end
    n_cmp++; if (t_lat !== 1 || t_rd !== 32'h0) begin n_err++; $display("FAIL zstrb_resp: got lat %0d data %h want 1/00000000", t_lat, t_rd); end
    issue(1'b0, 32'h2004, 1'b0, 4'h0, 32'h0); run_txn();
    n_cmp++; if (t_rd_seen !== 1'b0 || t_rd !== 32'hB1) begin n_err++; $display("FAIL zstrb_line_intact: got %b/%h want 0/000000b1", t_rd_seen, t_rd); end
  endtask

  task automatic test_reset_mid_refill();
    int k;
    set_beats(32'hD0);
    issue(1'b0, 32'h1008, 1'b0, 4'h0, 32'h0);
    k = 0;
    while (!mem_rd_req && k < 10) begin @(negedge clk); #1; k++; end
    n_cmp++; if (mem_rd_req !== 1'b1) begin n_err++; $display("FAIL rstmid_rd_req: got %b want 1", mem_rd_req); end
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_ret_valid = 1'b1; mem_ret_data = beats[b]; mem_ret_last = 1'b0;
      @(negedge clk);
    end
    mem_ret_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if ({req_ready, resp_valid, mem_rd_req, mem_wr_req} !== 4'b0000) begin n_err++; $display("FAIL rstmid_outputs: got %b want 0000", {req_ready, resp_valid, mem_rd_req, mem_wr_req}); end
    @(negedge clk);
    rst = 1'b1;
    set_beats(32'hE0);
    issue(1'b0, 32'h1008, 1'b0, 4'h0, 32'h0); run_txn();
    n_cmp++; if (t_rd_seen !== 1'b1) begin n_err++; $display("FAIL rstmid_miss_after: got %b want 1", t_rd_seen); end
    n_cmp++; if (t_rd !== 32'hE2) begin n_err++; $display("FAIL rstmid_refill_data: got %h want 000000e2", t_rd); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_uncached();
    test_invalidate();
    test_store_miss();
    test_zero_strobe();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
